// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   mdu_op_e    : operation codes (identical to RV-M funct3)
//   mdu_state_e : control FSM states
//   ZeroWord    : widest datapath zero, sliced to XLEN by users
//   rs1_signed / rs2_signed : per-op operand signedness
package ex_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } mdu_state_e;

    localparam logic [63:0] ZeroWord = '0;

    function automatic logic rs1_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mdu_divider.sv
// Iterative restoring radix-2 divider on unsigned (absolute) operands.
// The first quotient bit is produced on the start edge, so after XLEN
// edges in total (start + XLEN-1 busy cycles) the results are final.
//   clk, rst    : clock, synchronous active-high reset
//   start       : load operands and perform the first step
//   dividend    : unsigned dividend, sampled with start
//   divisor     : unsigned divisor (non-zero), sampled with start
//   busy        : further steps pending
//   quotient    : unsigned quotient
//   remainder   : unsigned remainder
module mdu_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN-1:0] src_rem, src_quo, dvs, step_rem, step_quo;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        src_rem  = start ? '0       : rem_q;
        src_quo  = start ? dividend : quo_q;
        dvs      = start ? divisor  : dvs_q;
        shifted  = {src_rem, src_quo[XLEN-1]};
        diff     = shifted - {1'b0, dvs};
        // remainder < divisor is invariant, so the MSB of diff is a clean borrow
        if (diff[XLEN]) begin
            step_rem = shifted[XLEN-1:0];
            step_quo = {src_quo[XLEN-2:0], 1'b0};
        end else begin
            step_rem = diff[XLEN-1:0];
            step_quo = {src_quo[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            cnt_q <= CNT_LOAD;
            quo_q <= step_quo;
            rem_q <= step_rem;
            dvs_q <= divisor;
        end else if (busy) begin
            cnt_q <= cnt_q - CNT_ONE;
            quo_q <= step_quo;
            rem_q <= step_rem;
        end
    end

    assign busy      = (cnt_q != '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// EX-stage RV-M multiply/divide unit.
//   clk, rst              : clock, synchronous active-high reset
//   valid_i, op_i         : request and RV-M funct3
//   rs1_i, rs2_i          : operands
//   wd_i, wreg_i          : destination register and write enable
//   flush_i               : cancel any in-flight operation
//   ready_o               : idle, a request can be accepted
//   stall_o               : hold the upstream pipeline
//   valid_o               : one-cycle result pulse
//   wdata_o, wd_o, wreg_o : result to EX/MEM (zero while valid_o is low)
module ex_mdu #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_ITER   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       rs1_i,
    input  logic [XLEN-1:0]       rs2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);

    import ex_mdu_pkg::*;

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    mdu_op_e               op_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;
    logic                  qneg_q, rneg_q, mplier_sgn_q;
    logic [2*XLEN-1:0]     mcand_q, acc_q;
    logic [XLEN-1:0]       mplier_q;

    logic                  res_valid_q;
    logic [XLEN-1:0]       res_q;
    logic [REG_ADDR_W-1:0] res_wd_q;
    logic                  res_wreg_q;

    logic                  accept, s1, s2, neg1, neg2, div_zero, div_ovf, div_start, div_busy;
    logic [XLEN-1:0]       abs1, abs2, special_res, quo, rem, q_fix, r_fix, div_res, mul_res;
    logic [2*XLEN-1:0]     mplier_ext, prod, addend, acc_d, mul_full;

    always_comb begin
        accept    = valid_i && (state_q == S_IDLE) && !flush_i && !rst;
        s1        = rs1_signed(op_i);
        s2        = rs2_signed(op_i);
        neg1      = s1 && rs1_i[XLEN-1];
        neg2      = s2 && rs2_i[XLEN-1];
        abs1      = neg1 ? ('0 - rs1_i) : rs1_i;
        abs2      = neg2 ? ('0 - rs2_i) : rs2_i;
        div_zero  = (rs2_i == '0);
        div_ovf   = s1 && (rs1_i == MOST_NEG) && (rs2_i == '1);
        div_start = accept && op_i[2] && !div_zero && !div_ovf;
        if (div_zero) begin
            special_res = op_i[1] ? rs1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : rs1_i;
        end
    end

    // Product modulo 2^(2*XLEN): the multiplicand is already sign/zero
    // extended, so only the multiplier's extension depends on the op.
    always_comb begin
        mplier_ext = mplier_sgn_q ? {{XLEN{mplier_q[XLEN-1]}}, mplier_q}
                                  : {{XLEN{1'b0}}, mplier_q};
        prod       = mcand_q * mplier_ext;
        addend     = mplier_q[0] ? mcand_q : '0;
        // Last shift-add step carries the multiplier MSB, whose weight is
        // negative for a signed multiplier.
        acc_d      = ((cnt_q == '0) && mplier_sgn_q) ? (acc_q - addend) : (acc_q + addend);
        mul_full   = (MUL_ITER != 0) ? acc_d : prod;
        mul_res    = (op_q == OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end

    always_comb begin
        q_fix   = qneg_q ? ('0 - quo) : quo;
        r_fix   = rneg_q ? ('0 - rem) : rem;
        div_res = ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_fix : q_fix;
    end

    mdu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (abs1),
        .divisor   (abs2),
        .busy      (div_busy),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= OP_MUL;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            mplier_sgn_q <= 1'b0;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
            res_wd_q     <= '0;
            res_wreg_q   <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_wd_q    <= '0;
            res_wreg_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q         <= mdu_op_e'(op_i);
                        wd_q         <= wd_i;
                        wreg_q       <= wreg_i;
                        mcand_q      <= {{XLEN{neg1}}, rs1_i};
                        mplier_q     <= rs2_i;
                        mplier_sgn_q <= s2;
                        acc_q        <= '0;
                        qneg_q       <= neg1 ^ neg2;
                        rneg_q       <= neg1;
                        cnt_q        <= CNT_LOAD;
                        if (!op_i[2]) begin
                            state_q <= S_MUL;
                        end else if (div_zero || div_ovf) begin
                            state_q     <= S_DONE;
                            cnt_q       <= '0;
                            res_valid_q <= 1'b1;
                            res_q       <= special_res;
                            res_wd_q    <= wd_i;
                            res_wreg_q  <= wreg_i;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if ((MUL_ITER == 0) || (cnt_q == '0)) begin
                        state_q     <= S_DONE;
                        cnt_q       <= '0;
                        res_valid_q <= 1'b1;
                        res_q       <= mul_res;
                        res_wd_q    <= wd_q;
                        res_wreg_q  <= wreg_q;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if ((cnt_q == '0) && !div_busy) begin
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_q       <= div_res;
                        res_wd_q    <= wd_q;
                        res_wreg_q  <= wreg_q;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A flush in the DONE cycle must still cancel the write-back.
    assign ready_o = (state_q == S_IDLE);
    assign stall_o = accept || (state_q == S_MUL) || (state_q == S_DIV);
    assign valid_o = res_valid_q && !flush_i;
    assign wdata_o = valid_o ? res_q : ZeroWord[XLEN-1:0];
    assign wd_o    = valid_o ? res_wd_q : '0;
    assign wreg_o  = valid_o && res_wreg_q;

endmodule
